// File: rtl/sid_pkg.sv
// Shared types for the SID register player: FSM states,
// the 30-bit command word and well-known SID readback addresses.
package sid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sid_state_t;

    // Command word layout {read, addr, data, wait}.
    typedef struct packed {
        logic        read;
        logic [4:0]  addr;
        logic [7:0]  data;
        logic [15:0] dly;
    } sid_cmd_t;

    localparam int CMD_W = $bits(sid_cmd_t);

    localparam logic [4:0] SID_OSC3 = 5'h1b;
    localparam logic [4:0] SID_ENV3 = 5'h1c;

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO with fall-through head.
// Ports: clk/rst, flush, push/push_data, pop/head, full/empty/level.
module sid_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sid_reg_player.sv
// Replays timed SID register commands onto the SID bus on 1 MHz ticks.
// Ports: cmd push stream in, SID cs/we/addr/data out, readback capture, status.
module sid_reg_player
    import sid_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_1mhz_ph1_en,
    input  logic                        i_flush,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_read,
    input  logic [4:0]                  i_cmd_addr,
    input  logic [7:0]                  i_cmd_data,
    input  logic [15:0]                 i_cmd_wait,
    output logic                        o_cs,
    output logic                        o_we,
    output logic [4:0]                  o_addr,
    output logic [7:0]                  o_data,
    input  logic [7:0]                  i_rd_data,
    output logic [7:0]                  o_rd_data,
    output logic                        o_rd_valid,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    sid_state_t  state;
    logic [15:0] cnt;
    sid_cmd_t    in_cmd;
    sid_cmd_t    head;
    logic        full;
    logic        empty;
    logic        slot_free;
    logic        do_load;

    assign in_cmd = '{read: i_cmd_read, addr: i_cmd_addr,
                      data: i_cmd_data, dly: i_cmd_wait};

    // Ready is a pure function of occupancy so a full FIFO
    // never accepts, even on a cycle that pops.
    assign o_cmd_ready = ~full & ~rst;
    assign o_busy      = (state != ST_IDLE) | ~empty;

    sid_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_flush),
        .push      (i_cmd_valid & o_cmd_ready),
        .push_data (in_cmd),
        .pop       (do_load),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (o_level)
    );

    always_comb begin
        slot_free = 1'b0;
        unique case (state)
            ST_IDLE:  slot_free = 1'b1;
            ST_ISSUE: slot_free = (cnt == 16'd0);
            ST_WAIT:  slot_free = (cnt == 16'd1);
            default:  slot_free = 1'b0;
        endcase
    end

    assign do_load = clk_1mhz_ph1_en & ~empty & slot_free & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_cs       <= 1'b0;
            o_we       <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else if (i_flush) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_cs       <= 1'b0;
            o_we       <= 1'b0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= 1'b0;
            if (clk_1mhz_ph1_en) begin
                unique case (state)
                    ST_ISSUE: begin
                        // In ISSUE o_we is the inverse of the read flag.
                        if (!o_we) begin
                            o_rd_data  <= i_rd_data;
                            o_rd_valid <= 1'b1;
                        end
                        o_cs  <= 1'b0;
                        o_we  <= 1'b0;
                        state <= (cnt == 16'd0) ? ST_IDLE : ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (cnt == 16'd1) state <= ST_IDLE;
                        else              cnt   <= cnt - 16'd1;
                    end
                    default: ;
                endcase
            end
            // A load overrides whatever the tick decided above.
            if (do_load) begin
                state  <= ST_ISSUE;
                cnt    <= head.dly;
                o_cs   <= 1'b1;
                o_we   <= ~head.read;
                o_addr <= head.addr;
                o_data <= head.read ? 8'h00 : head.data;
            end
        end
    end

endmodule

// File: tb/tb_sid_reg_player.sv
// Randomised + directed bench for sid_reg_player against a
// tick-schedule reference model of the command player.
module tb_sid_reg_player;
    import sid_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        rd = 1'b0;
    logic [4:0]  addr = '0;
    logic [7:0]  data = '0;
    logic [15:0] dly = '0;
    logic        o_cmd_ready, o_cs, o_we, o_rd_valid, o_busy;
    logic [4:0]  o_addr;
    logic [7:0]  o_data, o_rd_data, rd_bus;
    logic [4:0]  o_level;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] sid_rom(logic [4:0] a);
        return (a == 5'h1b) ? 8'h5a : ({a, 3'b101} ^ 8'hc3);
    endfunction

    assign rd_bus = sid_rom(o_addr);

    sid_reg_player #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_1mhz_ph1_en (en),
        .i_flush         (flush),
        .i_cmd_valid     (valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_read      (rd),
        .i_cmd_addr      (addr),
        .i_cmd_data      (data),
        .i_cmd_wait      (dly),
        .o_cs            (o_cs),
        .o_we            (o_we),
        .o_addr          (o_addr),
        .o_data          (o_data),
        .i_rd_data       (rd_bus),
        .o_rd_data       (o_rd_data),
        .o_rd_valid      (o_rd_valid),
        .o_busy          (o_busy),
        .o_level         (o_level)
    );

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // Enable generator.
    int en_period = 8;
    bit en_stall = 1'b0;
    int en_cnt = 0;
    always @(negedge clk) begin
        if (en_stall) begin
            en = 1'b0;
        end else begin
            en_cnt = (en_cnt + 1 >= en_period) ? 0 : en_cnt + 1;
            en = (en_cnt == 0);
        end
    end

    // Reference model: the bus carries one command per tick it was
    // loaded on; the next load may happen once tick >= sample + wait.
    sid_cmd_t   q[$];
    sid_cmd_t   cur;
    bit         on_bus = 0;
    int         tick = 0;
    int         next_tick = 0;
    logic       m_cs = 0, m_we = 0, m_rdv = 0;
    logic [4:0] m_addr = 0;
    logic [7:0] m_data = 0, m_rd = 0;
    bit         push_ok;

    always @(posedge clk) begin
        push_ok = valid && (q.size() < DEPTH);
        if (rst) begin
            q.delete();
            on_bus = 0; m_cs = 0; m_we = 0; m_rdv = 0;
            m_addr = 0; m_data = 0; m_rd = 0;
            tick = 0; next_tick = 0;
        end else if (flush) begin
            q.delete();
            on_bus = 0; m_cs = 0; m_we = 0; m_rdv = 0;
            next_tick = tick;
        end else begin
            m_rdv = 0;
            if (en) begin
                tick++;
                if (on_bus) begin
                    if (cur.read) begin
                        m_rd = sid_rom(cur.addr);
                        m_rdv = 1;
                    end
                    next_tick = tick + int'(cur.dly);
                    on_bus = 0;
                end
                if (!on_bus && tick >= next_tick && q.size() > 0) begin
                    cur = q.pop_front();
                    on_bus = 1;
                    m_addr = cur.addr;
                    m_data = cur.read ? 8'h00 : cur.data;
                end
            end
            m_cs = on_bus;
            m_we = on_bus && !cur.read;
            if (push_ok)
                q.push_back('{read: rd, addr: addr, data: data, dly: dly});
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cs", o_cs, m_cs);
        chk("we", o_we, m_we);
        chk("addr", o_addr, m_addr);
        chk("data", o_data, m_data);
        chk("rd_data", o_rd_data, m_rd);
        chk("rd_valid", o_rd_valid, m_rdv);
        chk("level", o_level, q.size());
        chk("busy", o_busy,
            on_bus || tick < next_tick || q.size() > 0);
        chk("ready", o_cmd_ready, !rst && q.size() < DEPTH);
    end

    // Bus monitor for the directed literal checks.
    int mt = 0;
    int samples = 0;
    int rdv_cnt = 0;
    int cs_fell = 0;
    int stick[$];
    bit swe[$];
    logic cs_prev = 0;
    always @(posedge clk) begin
        if (!rst && !flush && en) begin
            mt++;
            if (o_cs) begin
                samples++;
                stick.push_back(mt);
                swe.push_back(o_we);
            end
        end
        if (o_rd_valid) rdv_cnt++;
        if (cs_prev && !o_cs) cs_fell++;
        cs_prev = o_cs;
    end

    task automatic clr_mon();
        samples = 0; rdv_cnt = 0; cs_fell = 0;
    endtask

    task automatic push_cmd(bit r, logic [4:0] a, logic [7:0] d,
                            logic [15:0] w);
        int g = 0;
        @(negedge clk);
        valid = 1; rd = r; addr = a; data = d; dly = w;
        while (!o_cmd_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk("push_timeout", 0, 1);
        @(negedge clk);
        valid = 0;
    endtask

    task automatic wait_busy0(int lim);
        int g = 0;
        while (o_busy && g < lim) begin
            @(negedge clk);
            g++;
        end
        if (g >= lim) chk("busy_timeout", 1, 0);
    endtask

    task automatic wait_cs(logic v, int lim);
        int g = 0;
        while (o_cs !== v && g < lim) begin
            @(negedge clk);
            g++;
        end
        if (g >= lim) chk("cs_timeout", o_cs, v);
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
    endtask

    task automatic chk_reset_vals();
        chk("r_cs", o_cs, 0);
        chk("r_we", o_we, 0);
        chk("r_addr", o_addr, 0);
        chk("r_data", o_data, 0);
        chk("r_rd_data", o_rd_data, 0);
        chk("r_rd_valid", o_rd_valid, 0);
        chk("r_busy", o_busy, 0);
        chk("r_level", o_level, 0);
        chk("r_ready", o_cmd_ready, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("ready_in_rst", o_cmd_ready, 0);
        rst = 0;
        @(negedge clk);
        chk_reset_vals();

        // Single write.
        clr_mon();
        push_cmd(0, 5'h04, 8'h11, 0);
        wait_cs(1, 100);
        chk("t1_addr", o_addr, 5'h04);
        chk("t1_data", o_data, 8'h11);
        chk("t1_we", o_we, 1);
        wait_busy0(200);
        chk("t1_samples", samples, 1);

        // Three back-to-back writes.
        clr_mon();
        push_cmd(0, 5'h01, 8'ha1, 0);
        push_cmd(0, 5'h02, 8'ha2, 0);
        push_cmd(0, 5'h03, 8'ha3, 0);
        wait_busy0(300);
        chk("t2_samples", samples, 3);
        chk("t2_cs_fell", cs_fell, 1);

        // Wait 3 then write: four ticks apart.
        clr_mon();
        push_cmd(0, 5'h05, 8'h55, 3);
        push_cmd(0, 5'h06, 8'h66, 0);
        wait_busy0(400);
        chk("t3_samples", samples, 2);
        chk("t3_gap", stick[stick.size()-1] - stick[stick.size()-2], 4);

        // Read osc3.
        clr_mon();
        push_cmd(1, SID_OSC3, 8'hff, 0);
        wait_busy0(200);
        repeat (2) @(negedge clk);
        chk("t4_rd_data", o_rd_data, 8'h5a);
        chk("t4_rdv_pulses", rdv_cnt, 1);
        chk("t4_we", swe[swe.size()-1], 0);

        // Fill past depth with ticks stalled.
        clr_mon();
        en_stall = 1;
        for (int i = 0; i < DEPTH; i++)
            push_cmd(0, 5'(i), 8'(i * 3), 0);
        fork
            push_cmd(0, 5'h1f, 8'hee, 0);
            begin
                repeat (5) @(negedge clk);
                chk("t5_ready", o_cmd_ready, 0);
                chk("t5_level", o_level, DEPTH);
                en_stall = 0;
            end
        join
        wait_busy0(1000);
        chk("t5_samples", samples, DEPTH + 1);

        // Flush, then reset, in WAIT with five queued.
        for (int k = 0; k < 2; k++) begin
            push_cmd(0, 5'h07, 8'h77, 20);
            for (int i = 0; i < 5; i++)
                push_cmd(0, 5'(8 + i), 8'(i), 0);
            wait_cs(1, 100);
            wait_cs(0, 100);
            clr_mon();
            if (k == 0) begin
                do_flush();
                chk("t6_level", o_level, 0);
                chk("t6_busy", o_busy, 0);
                chk("t6_cs", o_cs, 0);
            end else begin
                @(negedge clk); rst = 1;
                @(negedge clk); rst = 0;
                @(negedge clk);
                chk_reset_vals();
            end
            repeat (100) @(negedge clk);
            chk("t6_no_bus", samples, 0);
        end

        // Random traffic.
        n = 0;
        for (int blk = 0; blk < 4; blk++) begin
            en_period = $urandom_range(1, 4);
            for (int i = 0; i < 50; i++) begin
                push_cmd($urandom_range(0, 3) == 0, 5'($urandom),
                         8'($urandom),
                         ($urandom_range(0, 7) == 0) ?
                             16'($urandom_range(0, 12)) :
                             16'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if ($urandom_range(0, 40) == 0) do_flush();
                n++;
            end
            wait_busy0(3000);
        end

        // Max wait, no wrap.
        en_period = 1;
        push_cmd(0, 5'h02, 8'h33, 16'hffff);
        push_cmd(0, 5'h03, 8'h44, 0);
        repeat (300) @(negedge clk);
        chk("t8_busy", o_busy, 1);
        do_flush();
        wait_busy0(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sid_reg_player.md
# sid_reg_player

Bus initiator for the SID register interface. Buffers a stream of timed register commands (address, data, read/write, post-delay) in a small FIFO and replays them onto the SID chip-select/address/data bus, aligned to the 1 MHz phase-1 enable. It sits in place of the CPU on the SID port for register-dump playback and automated audio tests. Read commands capture the SID readback byte, e.g. osc3 at 0x1b or env3 at 0x1c.

## Interface
Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- clk_1mhz_ph1_en  in  1  1 MHz tick enable; SID samples its bus on clk edges where this is high.
- i_flush  in  1  synchronous abort: empties FIFO, returns to IDLE.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  = FIFO not full; 0 while rst.
- i_cmd_read  in  1  1 = read command, 0 = write.
- i_cmd_addr  in  5  SID register address.
- i_cmd_data  in  8  write data; ignored for reads.
- i_cmd_wait  in  16  idle ticks N inserted after this command.
- o_cs, o_we  out  1  SID chip select / write enable.
- o_addr  out  5  SID address.
- o_data  out  8  SID write data.
- i_rd_data  in  8  SID readback (combinational in the SID from o_addr).
- o_rd_data  out  8  last captured read byte.
- o_rd_valid  out  1  one-clk pulse when o_rd_data updates.
- o_busy  out  1  state ≠ IDLE or FIFO non-empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Push on clk edge with i_cmd_valid & o_cmd_ready; o_cmd_ready does not depend on a same-cycle pop (full FIFO never accepts, even while popping).
- States: IDLE, ISSUE, WAIT.
- "Load": on a clk_1mhz_ph1_en edge with FIFO non-empty, pop; register o_cs=1, o_we=~read, o_addr, o_data (0 for reads), cnt=wait; go ISSUE.
- IDLE: on enable, load if non-empty; else stay.
- ISSUE: bus held constant until next enable edge (the SID sample edge). On that edge: if read, o_rd_data<=i_rd_data, o_rd_valid=1 next cycle. Then if cnt==0: load if non-empty (back-to-back) else clear o_cs/o_we, go IDLE. If cnt≠0: clear o_cs/o_we, go WAIT.
- WAIT: on enable, if cnt==1: load if non-empty else IDLE; else cnt<=cnt-1.
- Outside ISSUE, o_cs=o_we=0; o_addr/o_data hold last values.
- i_flush (priority over push/pop): FIFO level 0, state IDLE, o_cs=o_we=0, o_rd_valid=0; o_rd_data kept.
- Reset: all outputs 0 (o_cmd_ready=0 during rst, 1 first cycle after), FIFO empty, state IDLE, cnt=0.

## Timing
- Command sampled by SID at enable tick T0 → next command sampled earliest at T0+1+N (N=i_cmd_wait of the first).
- N=0 with FIFO non-empty: one command per 1 MHz tick, o_cs continuously high.
- First command after idle: loaded at first enable edge where FIFO already holds it (push must precede that edge by ≥1 clk), sampled at following enable.
- Push → o_level update: 1 clk. o_rd_valid: 1 clk after sample edge, width 1 clk.
- N=0xFFFF valid; cnt 16 bits, no wrap.
- Reset or flush mid-ISSUE: bus drops next clk, pending write is not performed if the sample edge has not occurred.

## Structure
- Shared package sid_pkg: state encodings, command word layout {read, addr, data, wait} (30 bits), register address constants 0x1b/0x1c.
- Sub-module sid_cmd_fifo: synchronous FIFO, parameter DEPTH/WIDTH, push/pop/flush, full/empty/level; read data registered-free (fall-through on head).
- Top: FSM, wait counter, bus/readback registers.

## Test plan
- Enable every 8 clks; push write {addr 0x04, data 0x11, wait 0} → o_cs=o_we=1, o_addr=0x04, o_data=0x11 held across exactly one enable edge; o_busy falls after.
- Push 3 writes, wait 0 → sampled on 3 consecutive enable edges, o_cs never drops.
- Write wait 3 then write → second sampled 4 ticks after first; o_cs low for 3 tick periods.
- Read addr 0x1b, i_rd_data=0x5a → o_we=0, o_rd_data=0x5a, single o_rd_valid pulse.
- Push 17 with DEPTH 16, enable stalled → o_cmd_ready=0 at level 16, 17th held until first pop; no loss, order preserved.
- Flush (then separately rst) during WAIT with 5 queued → level 0, IDLE, o_cs=0, no further bus activity; reset values on all outputs.
